// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scanner: segment patterns, digit limit
// and the index-width helper.
package sevseg_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; the dp bit is added by the scanner.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sevseg_hex_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_HEX[nibble];
    end

endmodule

// File: rtl/sevseg_scan_n.sv
// Time-multiplexed N-digit common-anode hex display driver with frame snapshot
// and dead time. Optional leading-zero blanking when SEVSEG_LZB_EN is defined.
module sevseg_scan_n
    import sevseg_pkg::*;
#(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [15:0] REFRESH_DIV  = 16'd50000,
    parameter logic [15:0] BLANK_CYCLES = 16'd500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [15:0]             presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    pending_q, pending_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    logic                    slot_tick;
    logic                    frame_wrap;
    logic                    lz_blank;
    logic [3:0]              cur_nib;
    logic [6:0]              seg_hex;
    logic [3:0]              nib_arr [NUM_DIGITS];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib_arr[gi] = snap_val_q[4*gi +: 4];
        end
    endgenerate

    assign cur_nib = nib_arr[idx_q];

    sevseg_hex_decode u_dec (
        .nibble (cur_nib),
        .seg_n  (seg_hex)
    );

`ifdef SEVSEG_LZB_EN
    // hi_zero[i]: snapshot nibble i and every nibble above it are zero.
    logic [NUM_DIGITS-1:0] hi_zero;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign hi_zero[gi] = (nib_arr[gi] == 4'h0);
            end else begin : g_mid
                assign hi_zero[gi] = (nib_arr[gi] == 4'h0) && hi_zero[gi+1];
            end
        end
    endgenerate
    assign lz_blank = (idx_q != '0) && hi_zero[idx_q] && !snap_dp_q[idx_q];
`else
    assign lz_blank = 1'b0;
`endif

    assign slot_tick  = (presc_q == REFRESH_DIV - 16'd1);
    assign frame_wrap = slot_tick && (idx_q == LAST_IDX);

    always_comb begin
        presc_d       = presc_q;
        idx_d         = idx_q;
        snap_val_d    = snap_val_q;
        snap_dp_d     = snap_dp_q;
        pending_d     = pending_q;
        seg_d         = SEG_BLANK;
        an_d          = '1;
        frame_start_d = 1'b0;

        if (en) begin
            presc_d = slot_tick ? 16'd0 : presc_q + 16'd1;
            if (slot_tick) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
            // pending_q covers the first enabled cycle after reset release.
            if (frame_wrap || pending_q) begin
                snap_val_d    = value;
                snap_dp_d     = dp;
                pending_d     = 1'b0;
                frame_start_d = 1'b1;
            end
            if (presc_q >= BLANK_CYCLES) begin
                an_d  = ~(NUM_DIGITS'(1) << idx_q);
                seg_d = lz_blank ? SEG_BLANK : {~snap_dp_q[idx_q], seg_hex};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= '0;
            snap_val_q    <= '0;
            snap_dp_q     <= '0;
            pending_q     <= 1'b1;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            snap_val_q    <= snap_val_d;
            snap_dp_q     <= snap_dp_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevseg_scan_n.sv
// Directed bench for sevseg_scan_n with 4 digits, 4-cycle slots, 1-cycle dead time.
module tb_sevseg_scan_n;

`ifdef SEVSEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sevseg_scan_n #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (16'd4),
        .BLANK_CYCLES (16'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .value       (value),
        .dp          (dp),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and compare the registered pins just after the edge.
    task automatic expect_cyc(input string tag, input logic [3:0] an_e,
                              input logic [7:0] seg_e, input logic fs_e);
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d %s an=%b seg=%h fs=%b", cyc, tag, an, seg, frame_start);
        checks++;
        assert (an === an_e) else begin
            failures++;
            $error("FAIL %s.an cyc=%0d got=%b exp=%b", tag, cyc, an, an_e);
        end
        checks++;
        assert (seg === seg_e) else begin
            failures++;
            $error("FAIL %s.seg cyc=%0d got=%h exp=%h", tag, cyc, seg, seg_e);
        end
        checks++;
        assert (frame_start === fs_e) else begin
            failures++;
            $error("FAIL %s.fs cyc=%0d got=%b exp=%b", tag, cyc, frame_start, fs_e);
        end
    endtask

    // One full slot: dead-time cycle then three lit cycles.
    task automatic slot(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e,
                        input logic fs_blank, input logic fs_last);
        expect_cyc(tag, 4'b1111, 8'hFF, fs_blank);
        expect_cyc(tag, an_e, seg_e, 1'b0);
        expect_cyc(tag, an_e, seg_e, 1'b0);
        expect_cyc(tag, an_e, seg_e, fs_last);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        value = 16'h0000;
        dp    = 4'b0000;
        expect_cyc("reset", 4'b1111, 8'hFF, 1'b0);
        expect_cyc("reset", 4'b1111, 8'hFF, 1'b0);

        // Basic scan of 1234; snapshot and frame_start on the first enabled cycle.
        rst   = 1'b0;
        en    = 1'b1;
        value = 16'h1234;
        slot("f1d0", 4'b1110, 8'h99, 1'b1, 1'b0);
        slot("f1d1", 4'b1101, 8'hB0, 1'b0, 1'b0);
        slot("f1d2", 4'b1011, 8'hA4, 1'b0, 1'b0);
        slot("f1d3", 4'b0111, 8'hF9, 1'b0, 1'b1);

        // Mid-frame change stays invisible until the next snapshot.
        slot("f2d0", 4'b1110, 8'h99, 1'b0, 1'b0);
        value = 16'hFFFF;
        slot("f2d1", 4'b1101, 8'hB0, 1'b0, 1'b0);
        slot("f2d2", 4'b1011, 8'hA4, 1'b0, 1'b0);
        slot("f2d3", 4'b0111, 8'hF9, 1'b0, 1'b1);

        slot("f3d0", 4'b1110, 8'h8E, 1'b0, 1'b0);
        value = 16'h0800;
        dp    = 4'b0100;
        slot("f3d1", 4'b1101, 8'h8E, 1'b0, 1'b0);
        slot("f3d2", 4'b1011, 8'h8E, 1'b0, 1'b0);
        slot("f3d3", 4'b0111, 8'h8E, 1'b0, 1'b1);

        // Decimal point on digit 2.
        slot("dp_d0", 4'b1110, 8'hC0, 1'b0, 1'b0);
        slot("dp_d1", 4'b1101, 8'hC0, 1'b0, 1'b0);
        slot("dp_d2", 4'b1011, 8'h00, 1'b0, 1'b0);
        slot("dp_d3", 4'b0111, LZB ? 8'hFF : 8'hC0, 1'b0, 1'b1);

        // Pause during digit 2 after one lit cycle, then resume.
        slot("en_d0", 4'b1110, 8'hC0, 1'b0, 1'b0);
        slot("en_d1", 4'b1101, 8'hC0, 1'b0, 1'b0);
        expect_cyc("en_d2", 4'b1111, 8'hFF, 1'b0);
        expect_cyc("en_d2", 4'b1011, 8'h00, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_cyc("en_off", 4'b1111, 8'hFF, 1'b0);
        end
        en = 1'b1;
        expect_cyc("en_resume", 4'b1011, 8'h00, 1'b0);
        expect_cyc("en_resume", 4'b1011, 8'h00, 1'b0);
        slot("en_d3", 4'b0111, LZB ? 8'hFF : 8'hC0, 1'b0, 1'b1);

        // Reset in the middle of digit 3; new value snapshotted on release.
        slot("rs_d0", 4'b1110, 8'hC0, 1'b0, 1'b0);
        slot("rs_d1", 4'b1101, 8'hC0, 1'b0, 1'b0);
        slot("rs_d2", 4'b1011, 8'h00, 1'b0, 1'b0);
        expect_cyc("rs_d3", 4'b1111, 8'hFF, 1'b0);
        expect_cyc("rs_d3", 4'b0111, LZB ? 8'hFF : 8'hC0, 1'b0);
        value = 16'h0042;
        dp    = 4'b0000;
        rst   = 1'b1;
        expect_cyc("rst_mid", 4'b1111, 8'hFF, 1'b0);
        rst = 1'b0;
        slot("r42_d0", 4'b1110, 8'hA4, 1'b1, 1'b0);
        slot("r42_d1", 4'b1101, 8'h99, 1'b0, 1'b0);
        slot("r42_d2", 4'b1011, LZB ? 8'hFF : 8'hC0, 1'b0, 1'b0);
        value = 16'h0000;
        slot("r42_d3", 4'b0111, LZB ? 8'hFF : 8'hC0, 1'b0, 1'b1);

        // All-zero value: only digit 0 survives leading-zero blanking.
        slot("z_d0", 4'b1110, 8'hC0, 1'b0, 1'b0);
        slot("z_d1", 4'b1101, LZB ? 8'hFF : 8'hC0, 1'b0, 1'b0);
        slot("z_d2", 4'b1011, LZB ? 8'hFF : 8'hC0, 1'b0, 1'b0);
        slot("z_d3", 4'b0111, LZB ? 8'hFF : 8'hC0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
